imem_boot_loader: RTL and testbench
===================================

# imem_boot_loader

Parametrised boot loader between an external word stream and the instruction-memory load port of `cpu_top`. Accepts a framed image (header, payload, XOR checksum) over a valid/ready stream and writes each payload word into instruction memory, wrapping addresses modulo depth. Holds the core in reset until the image is complete and verified, then releases it. Replaces the ad-hoc drive of `load_mem_en`/`load_mem_addr`/`load_mem_data` with a checked, restartable sequence.

## Interface
- `DATA_W`, 32, instruction and stream word width; must be ≥ `ADDR_W`+1.
- `ADDR_W`, 5, instruction memory address width.
- `DEPTH`, 2**`ADDR_W`, words in instruction memory; addresses wrap modulo `DEPTH`.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERROR.
- `base_addr`  in  `ADDR_W`  first write address; sampled on accepted `start`.
- `s_valid`  in  1  stream word valid.
- `s_data`  in  `DATA_W`  stream word.
- `s_ready`  out  1  loader accepts `s_data` this cycle.
- `load_mem_en`  out  1  instruction memory write enable.
- `load_mem_addr`  out  `ADDR_W`  write address.
- `load_mem_data`  out  `DATA_W`  write data.
- `cpu_rst_n`  out  1  active-low reset to the core; low unless in DONE.
- `done`  out  1  image loaded and checksum matched.
- `error`  out  1  bad count or checksum mismatch.
- `words_loaded`  out  `ADDR_W`+1  payload words written since last `start`.

## Operation
- States: IDLE, HEADER, LOAD, CHECK, DONE, ERROR.
- IDLE: `s_ready`=0. `start` → latch `base_addr`, clear checksum and `words_loaded`, go HEADER.
- HEADER: `s_ready`=1. On handshake, count N = `s_data[ADDR_W:0]`. N=0 or N>`DEPTH` → ERROR; else LOAD.
- LOAD: `s_ready`=1. Each handshake writes the word to current address, XORs it into checksum, increments address (wraps `DEPTH`-1 → 0) and `words_loaded`. After N-th word → CHECK.
- CHECK: `s_ready`=1. On handshake, `s_data` == accumulated XOR → DONE, else ERROR.
- DONE: `done`=1, `cpu_rst_n`=1, `s_ready`=0. `start` → HEADER (core re-held in reset).
- ERROR: `error`=1, `cpu_rst_n`=0, `s_ready`=0. `start` → HEADER.
- `start` in HEADER/LOAD/CHECK ignored. Stream words while `s_ready`=0 are not consumed.
- Overlapping wrap (N=`DEPTH` from nonzero base) is legal; every location written exactly once.

## Timing
- Reset values: state IDLE, `s_ready`=0, `load_mem_en`=0, `load_mem_addr`=0, `load_mem_data`=0, `cpu_rst_n`=0, `done`=0, `error`=0, `words_loaded`=0.
- All outputs registered except `s_ready` (decoded from state).
- Write latency: handshake in cycle t → `load_mem_en`=1 with address/data in cycle t+1, one cycle only; back-to-back handshakes give back-to-back writes.
- `start` accepted in cycle t → HEADER, `s_ready`=1 in t+1.
- Checksum handshake in cycle t → `done`/`error` and `cpu_rst_n` update in t+1.
- `start` out of DONE: `cpu_rst_n`, `done` drop in the next cycle.
- `rst_n` low mid-load: immediate return to reset values; partially written memory untouched, core stays in reset.
- No timeout: stalled stream holds state indefinitely.

## Structure
- Shared package `imem_boot_pkg`: state enum, header count field position, checksum function (XOR over `DATA_W`).
- Single flat module; no sub-module needed. Address/count counters and the checksum register are internal.

## Test plan
- Default params, `base_addr`=0, header 32, 32 payload words 0x1000_0000+i, correct XOR → writes at addresses 0..31 with matching data, `words_loaded`=32, `done`=1, `cpu_rst_n`=1 one cycle after checksum.
- Same image with random `s_valid` gaps → identical write sequence; no write in cycles without handshake.
- `base_addr`=30, header 4, words A,B,C,D → writes at 30,31,0,1; `done`=1.
- Correct payload, checksum XOR^1 → `error`=1, `done`=0, `cpu_rst_n` stays 0; then `start` and a good image → `done`=1.
- Header 0 and header 33 → ERROR after header handshake, zero writes.
- `rst_n` pulsed low after 10 of 32 words → all outputs at reset values same cycle; `start` with full image then completes with `done`=1.

Source files
------------

// File: rtl/imem_boot_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM encodings,
// header field position and the running checksum step.
package imem_boot_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_HEADER = 3'd1;
    localparam logic [STATE_W-1:0] ST_LOAD   = 3'd2;
    localparam logic [STATE_W-1:0] ST_CHECK  = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE   = 3'd4;
    localparam logic [STATE_W-1:0] ST_ERROR  = 3'd5;

    // Payload word count occupies s_data[COUNT_LSB +: ADDR_W+1] of the header word.
    localparam int COUNT_LSB = 0;

    // Widest stream word the checksum helper supports; narrower words are zero-extended.
    localparam int CSUM_MAX_W = 64;

    function automatic logic [CSUM_MAX_W-1:0] checksum_step(
        input logic [CSUM_MAX_W-1:0] acc,
        input logic [CSUM_MAX_W-1:0] word
    );
        return acc ^ word;
    endfunction

endpackage

// File: rtl/imem_boot_loader.sv
// Loads a framed image (header count, payload, XOR checksum) into instruction
// memory and keeps the core in reset until the image is verified.
module imem_boot_loader
    import imem_boot_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              load_mem_en,
    output logic [ADDR_W-1:0] load_mem_addr,
    output logic [DATA_W-1:0] load_mem_data,
    output logic              cpu_rst_n,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH-1);

    logic [STATE_W-1:0]    state;
    logic [STATE_W-1:0]    state_next;
    logic [ADDR_W-1:0]     addr;
    logic [ADDR_W-1:0]     addr_inc;
    logic [ADDR_W:0]       count;
    logic [ADDR_W:0]       loaded;
    logic [ADDR_W:0]       loaded_inc;
    logic [ADDR_W:0]       hdr_count;
    logic [CSUM_MAX_W-1:0] csum;
    logic [CSUM_MAX_W-1:0] data_ext;

    logic start_ok;
    logic handshake;
    logic hdr_bad;
    logic last_word;
    logic csum_ok;

    assign s_ready = (state == ST_HEADER) || (state == ST_LOAD) || (state == ST_CHECK);

    assign handshake = s_valid && s_ready;
    assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));

    assign hdr_count = s_data[COUNT_LSB +: ADDR_W+1];
    assign hdr_bad   = (hdr_count == '0) || (hdr_count > DEPTH_CNT);

    assign loaded_inc = loaded + 1'b1;
    assign last_word  = (loaded_inc == count);
    assign addr_inc   = (addr == LAST_ADDR) ? '0 : addr + 1'b1;

    always_comb begin
        data_ext = '0;
        data_ext[DATA_W-1:0] = s_data;
    end

    assign csum_ok = (data_ext == csum);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_ok) begin
                    state_next = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (handshake) begin
                    state_next = hdr_bad ? ST_ERROR : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (handshake && last_word) begin
                    state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (handshake) begin
                    state_next = csum_ok ? ST_DONE : ST_ERROR;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they change together with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            done      <= 1'b0;
            error     <= 1'b0;
            cpu_rst_n <= 1'b0;
        end else begin
            state     <= state_next;
            done      <= (state_next == ST_DONE);
            error     <= (state_next == ST_ERROR);
            cpu_rst_n <= (state_next == ST_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr   <= '0;
            count  <= '0;
            loaded <= '0;
            csum   <= '0;
        end else if (start_ok) begin
            addr   <= base_addr;
            count  <= '0;
            loaded <= '0;
            csum   <= '0;
        end else if (handshake && (state == ST_HEADER)) begin
            count <= hdr_count;
        end else if (handshake && (state == ST_LOAD)) begin
            addr   <= addr_inc;
            loaded <= loaded_inc;
            csum   <= checksum_step(csum, data_ext);
        end
    end

    // One write pulse per accepted payload word; address/data hold between writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_mem_en   <= 1'b0;
            load_mem_addr <= '0;
            load_mem_data <= '0;
        end else begin
            load_mem_en <= handshake && (state == ST_LOAD);
            if (handshake && (state == ST_LOAD)) begin
                load_mem_addr <= addr;
                load_mem_data <= s_data;
            end
        end
    end

    assign words_loaded = loaded;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: a vector table of whole images plus
// hand-written sequences for latency, restart and mid-load reset behaviour.
module tb_imem_boot_loader;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              load_mem_en;
    logic [ADDR_W-1:0] load_mem_addr;
    logic [DATA_W-1:0] load_mem_data;
    logic              cpu_rst_n;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    imem_boot_loader #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .base_addr    (base_addr),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .load_mem_en  (load_mem_en),
        .load_mem_addr(load_mem_addr),
        .load_mem_data(load_mem_data),
        .cpu_rst_n    (cpu_rst_n),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    typedef struct {
        logic [ADDR_W-1:0] base;
        logic [DATA_W-1:0] header;
        int                n_send;
        logic [DATA_W-1:0] seed;
        logic [DATA_W-1:0] csum_flip;
        bit                gaps;
        bit                exp_done;
        bit                exp_error;
        int                exp_words;
    } vec_t;

    wr_t  wr_q[$];
    vec_t vecs[9];
    int   errors = 0;
    int   checks = 0;

    // Record every memory write seen by the instruction memory.
    always @(negedge clk) begin
        if (rst_n && load_mem_en) begin
            wr_q.push_back('{addr: load_mem_addr, data: load_mem_data});
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [DATA_W-1:0] w, input int gap);
        int n;
        s_valid = 1'b0;
        repeat (gap) @(negedge clk);
        s_data  = w;
        s_valid = 1'b1;
        n = 0;
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            checkOutput("stream_timeout", 64'(s_ready), 64'(1));
            s_valid = 1'b0;
        end else begin
            @(negedge clk);
            s_valid = 1'b0;
        end
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] b);
        base_addr = b;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, "_s_ready"},   64'(s_ready),       64'(0));
        checkOutput({tag, "_mem_en"},    64'(load_mem_en),   64'(0));
        checkOutput({tag, "_mem_addr"},  64'(load_mem_addr), 64'(0));
        checkOutput({tag, "_mem_data"},  64'(load_mem_data), 64'(0));
        checkOutput({tag, "_cpu_rst_n"}, 64'(cpu_rst_n),     64'(0));
        checkOutput({tag, "_done"},      64'(done),          64'(0));
        checkOutput({tag, "_error"},     64'(error),         64'(0));
        checkOutput({tag, "_words"},     64'(words_loaded),  64'(0));
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [DATA_W-1:0] csum;
        logic [DATA_W-1:0] w;
        wr_q.delete();
        pulse_start(v.base);
        checkOutput("start_to_ready", 64'(s_ready), 64'(1));
        push_word(v.header, v.gaps ? int'($urandom_range(2, 0)) : 0);
        csum = '0;
        for (int i = 0; i < v.n_send; i++) begin
            w    = v.seed + DATA_W'(i);
            csum = csum ^ w;
            push_word(w, v.gaps ? int'($urandom_range(3, 0)) : 0);
        end
        if (v.n_send > 0) begin
            push_word(csum ^ v.csum_flip, v.gaps ? int'($urandom_range(2, 0)) : 0);
        end
    endtask

    task automatic checkResult(input int idx, input vec_t v);
        int nchk;
        checkOutput($sformatf("v%0d_done", idx),      64'(done),         64'(v.exp_done));
        checkOutput($sformatf("v%0d_error", idx),     64'(error),        64'(v.exp_error));
        checkOutput($sformatf("v%0d_cpu_rst_n", idx), 64'(cpu_rst_n),    64'(v.exp_done));
        checkOutput($sformatf("v%0d_words", idx),     64'(words_loaded), 64'(v.exp_words));
        checkOutput($sformatf("v%0d_ready_low", idx), 64'(s_ready),      64'(0));
        #1;
        checkOutput($sformatf("v%0d_write_count", idx), 64'(wr_q.size()), 64'(v.exp_words));
        nchk = (wr_q.size() < v.exp_words) ? wr_q.size() : v.exp_words;
        for (int i = 0; i < nchk; i++) begin
            checkOutput($sformatf("v%0d_wr%0d_addr", idx, i), 64'(wr_q[i].addr), 64'((int'(v.base) + i) % DEPTH));
            checkOutput($sformatf("v%0d_wr%0d_data", idx, i), 64'(wr_q[i].data), 64'(v.seed + DATA_W'(i)));
        end
    endtask

    initial begin
        int snap;
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        s_valid   = 1'b0;
        s_data    = '0;

        vecs[0] = '{5'd0,  32'd32,          32, 32'h1000_0000, 32'h0, 1'b0, 1'b1, 1'b0, 32};
        vecs[1] = '{5'd0,  32'd32,          32, 32'h1000_0000, 32'h0, 1'b1, 1'b1, 1'b0, 32};
        vecs[2] = '{5'd30, 32'd4,           4,  32'h0000_000A, 32'h0, 1'b0, 1'b1, 1'b0, 4};
        vecs[3] = '{5'd0,  32'd32,          32, 32'h1000_0000, 32'h1, 1'b0, 1'b0, 1'b1, 32};
        vecs[4] = '{5'd0,  32'd32,          32, 32'h1000_0000, 32'h0, 1'b0, 1'b1, 1'b0, 32};
        vecs[5] = '{5'd0,  32'd0,           0,  32'h0,         32'h0, 1'b0, 1'b0, 1'b1, 0};
        vecs[6] = '{5'd0,  32'd33,          0,  32'h0,         32'h0, 1'b0, 1'b0, 1'b1, 0};
        vecs[7] = '{5'd31, 32'hABCD_FFC1,   1,  32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1, 1'b0, 1};
        vecs[8] = '{5'd5,  32'd32,          32, 32'h5555_0000, 32'h0, 1'b1, 1'b1, 1'b0, 32};

        repeat (3) @(negedge clk);
        check_reset_values("por");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("idle");

        for (int k = 0; k < 9; k++) begin
            applyStimulus(vecs[k]);
            checkResult(k, vecs[k]);
        end

        // Write latency and back-to-back spacing; start is ignored while mid-image.
        pulse_start(5'd3);
        push_word(32'd2, 0);
        push_word(32'h0000_1111, 0);
        checkOutput("lat_en",   64'(load_mem_en),   64'(1));
        checkOutput("lat_addr", 64'(load_mem_addr), 64'(3));
        checkOutput("lat_data", 64'(load_mem_data), 64'(32'h0000_1111));
        @(negedge clk);
        checkOutput("lat_single_pulse", 64'(load_mem_en), 64'(0));
        push_word(32'h0000_2222, 0);
        checkOutput("lat2_addr", 64'(load_mem_addr), 64'(4));
        pulse_start(5'd9);
        checkOutput("ign_start_ready", 64'(s_ready),      64'(1));
        checkOutput("ign_start_words", 64'(words_loaded), 64'(2));
        push_word(32'h0000_3333, 0);
        checkOutput("short_done",  64'(done),         64'(1));
        checkOutput("short_words", 64'(words_loaded), 64'(2));

        // Stream words offered while not ready must not be consumed.
        #1;
        snap    = wr_q.size();
        s_data  = 32'd5;
        s_valid = 1'b1;
        repeat (3) @(negedge clk);
        s_valid = 1'b0;
        checkOutput("noready_words", 64'(words_loaded), 64'(2));
        checkOutput("noready_done",  64'(done),         64'(1));
        #1;
        checkOutput("noready_writes", 64'(wr_q.size()), 64'(snap));

        // Restart out of DONE drops the core release on the next cycle.
        pulse_start(5'd0);
        checkOutput("restart_done",  64'(done),         64'(0));
        checkOutput("restart_cpu",   64'(cpu_rst_n),    64'(0));
        checkOutput("restart_ready", 64'(s_ready),      64'(1));
        checkOutput("restart_words", 64'(words_loaded), 64'(0));

        // Asynchronous reset in the middle of a payload.
        push_word(32'd32, 0);
        for (int i = 0; i < 10; i++) begin
            push_word(32'h7000_0000 + DATA_W'(i), 0);
        end
        checkOutput("mid_words", 64'(words_loaded), 64'(10));
        checkOutput("mid_en",    64'(load_mem_en),  64'(1));
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(vecs[0]);
        checkResult(9, vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
